sal_rd_return: RTL and testbench

//  Read-data return stage of the DDR2 controller; sits downstream of the DFI read interface.

---
 rtl/sal_ddr2_pkg.sv | 18 +
 rtl/sal_sync_fifo.sv | 66 ++++++
 rtl/sal_rd_return.sv | 174 +++++++++++++++++
 tb/tb_sal_rd_return.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sal_ddr2_pkg.sv
// Shared DDR2 controller types: AXI ID/length, read tag record, AXI response codes.
package sal_ddr2_pkg;

  localparam int unsigned AXI_ID_W  = 4;
  localparam int unsigned AXI_LEN_W = 4;

  typedef logic [AXI_ID_W-1:0]  axi_id_t;
  typedef logic [AXI_LEN_W-1:0] axi_len_t;

  typedef struct packed {
    axi_id_t  id;
    axi_len_t len;
  } rd_tag_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/sal_sync_fifo.sv
// Synchronous FIFO: flop-based storage, head entry presented on rd_data,
// full/empty/count status. Push while full is accepted only with a same-cycle pop.
module sal_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Qualify push/pop against occupancy and advance pointers/count.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset because empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/sal_rd_return.sv
// DDR2 read-data return stage: buffers DFI read beats, tags bursts with the
// AXI ID/len recorded at READ issue, and drives the AXI R channel.
// Optional feature macro: SAL_RD_PARITY_EN (per-byte even parity -> SLVERR).
module sal_rd_return
  import sal_ddr2_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned ID_W       = 4,
  parameter int unsigned LEN_W      = 4,
  parameter int unsigned TAG_DEPTH  = 8,
  parameter int unsigned DATA_DEPTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_issue_valid,
  output logic                rd_issue_ready,
  input  logic [ID_W-1:0]     rd_issue_id,
  input  logic [LEN_W-1:0]    rd_issue_len,
  input  logic                dfi_rddata_valid,
  input  logic [DATA_W-1:0]   dfi_rddata,
  input  logic [DATA_W/8-1:0] dfi_rddata_par,
  output logic                rvalid,
  input  logic                rready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                err_overflow,
  output logic                err_orphan
);

  localparam int unsigned TAG_W = ID_W + LEN_W;
  localparam int unsigned CW    = $clog2(DATA_DEPTH) + 1;
  localparam int unsigned SW    = CW + 1;
`ifdef SAL_RD_PARITY_EN
  localparam int unsigned DF_W  = DATA_W + 1;
`else
  localparam int unsigned DF_W  = DATA_W;
`endif

  logic [TAG_W-1:0]             tag_wr, tag_rd;
  logic                         tag_push, tag_pop, tag_full, tag_empty;
  logic [$clog2(TAG_DEPTH):0]   tag_count;
  logic [DF_W-1:0]              data_wr, data_rd;
  logic                         data_push, data_pop, data_full, data_empty;
  logic [$clog2(DATA_DEPTH):0]  data_count;
  logic                         unused_cnt;

  logic [ID_W-1:0]  head_id;
  logic [LEN_W-1:0] head_len;
  logic             head_last, hs;
  logic [CW-1:0]    len_beats;

  logic [CW-1:0]    credits_q, credits_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             err_overflow_q, err_overflow_d;
  logic             err_orphan_q, err_orphan_d;
  logic [SW-1:0]    credit_sum;

  assign unused_cnt = ^{tag_count, data_count};

  sal_sync_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (tag_push),
    .wr_data (tag_wr),
    .pop     (tag_pop),
    .rd_data (tag_rd),
    .full    (tag_full),
    .empty   (tag_empty),
    .count   (tag_count)
  );

  sal_sync_fifo #(
    .WIDTH (DF_W),
    .DEPTH (DATA_DEPTH)
  ) u_data_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (data_push),
    .wr_data (data_wr),
    .pop     (data_pop),
    .rd_data (data_rd),
    .full    (data_full),
    .empty   (data_empty),
    .count   (data_count)
  );

`ifdef SAL_RD_PARITY_EN
  logic beat_perr;

  // Per-byte even parity check of the incoming DFI beat.
  always_comb begin
    beat_perr = 1'b0;
    for (int unsigned b = 0; b < DATA_W/8; b++) begin
      if ((^dfi_rddata[b*8 +: 8]) != dfi_rddata_par[b]) beat_perr = 1'b1;
    end
    data_wr = {beat_perr, dfi_rddata};
  end
`else
  logic unused_par;
  assign unused_par = ^dfi_rddata_par;

  // Data FIFO carries the raw beat only.
  always_comb begin
    data_wr = dfi_rddata;
  end
`endif

  // Issue gating, R channel outputs and FIFO control.
  always_comb begin
    tag_wr         = {rd_issue_id, rd_issue_len};
    head_id        = tag_rd[TAG_W-1:LEN_W];
    head_len       = tag_rd[LEN_W-1:0];
    len_beats      = CW'(rd_issue_len) + CW'(1);
    rd_issue_ready = !tag_full && (credits_q >= len_beats);
    tag_push       = rd_issue_valid && rd_issue_ready;

    rvalid    = !data_empty && !tag_empty;
    head_last = (beat_cnt_q == head_len);
    hs        = rvalid && rready;
    tag_pop   = hs && head_last;
    data_pop  = hs;

    rid   = rvalid ? head_id : '0;
    rdata = rvalid ? data_rd[DATA_W-1:0] : '0;
    rlast = rvalid && head_last;
    rresp = RESP_OKAY;
`ifdef SAL_RD_PARITY_EN
    if (rvalid && data_rd[DATA_W]) rresp = RESP_SLVERR;
`endif

    // Beats with no burst to belong to are dropped; a full FIFO accepts only
    // when the same edge frees a slot.
    data_push = dfi_rddata_valid && !tag_empty && (!data_full || hs);
  end

  // Next state for credits, beat counter and sticky error flags.
  always_comb begin
    credit_sum = {1'b0, credits_q} + SW'(hs);
    if (tag_push) credit_sum = credit_sum - {1'b0, len_beats};
    if (credit_sum > SW'(DATA_DEPTH)) credit_sum = SW'(DATA_DEPTH);
    credits_d = credit_sum[CW-1:0];

    beat_cnt_d = beat_cnt_q;
    if (hs) beat_cnt_d = head_last ? '0 : beat_cnt_q + LEN_W'(1);

    err_orphan_d   = err_orphan_q || (dfi_rddata_valid && tag_empty);
    err_overflow_d = err_overflow_q ||
                     (dfi_rddata_valid && !tag_empty && data_full && !hs);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits_q      <= CW'(DATA_DEPTH);
      beat_cnt_q     <= '0;
      err_orphan_q   <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      credits_q      <= credits_d;
      beat_cnt_q     <= beat_cnt_d;
      err_orphan_q   <= err_orphan_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign err_orphan   = err_orphan_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_sal_rd_return.sv
// Self-checking bench for sal_rd_return: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_sal_rd_return;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_issue_valid;
  logic        rd_issue_ready;
  logic [3:0]  rd_issue_id;
  logic [3:0]  rd_issue_len;
  logic        dfi_rddata_valid;
  logic [63:0] dfi_rddata;
  logic [7:0]  dfi_rddata_par;
  logic        rvalid;
  logic        rready;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        err_overflow;
  logic        err_orphan;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sal_rd_return #(
    .DATA_W     (64),
    .ID_W       (4),
    .LEN_W      (4),
    .TAG_DEPTH  (8),
    .DATA_DEPTH (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .rd_issue_valid   (rd_issue_valid),
    .rd_issue_ready   (rd_issue_ready),
    .rd_issue_id      (rd_issue_id),
    .rd_issue_len     (rd_issue_len),
    .dfi_rddata_valid (dfi_rddata_valid),
    .dfi_rddata       (dfi_rddata),
    .dfi_rddata_par   (dfi_rddata_par),
    .rvalid           (rvalid),
    .rready           (rready),
    .rid              (rid),
    .rdata            (rdata),
    .rresp            (rresp),
    .rlast            (rlast),
    .err_overflow     (err_overflow),
    .err_orphan       (err_orphan)
  );

`ifdef SAL_RD_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // Reference model: outstanding bursts, buffered beats, credit count.
  typedef struct { int id; int len; } burst_t;
  typedef struct { logic [63:0] d; bit perr; } beat_t;
  burst_t tq[$];
  beat_t  dq[$];
  int     m_credits;
  int     m_idx;
  bit     m_orphan, m_ovf;
  int     pending_dfi;

  function automatic logic [7:0] even_par(input logic [63:0] d);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = ^d[i*8 +: 8];
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_rvalid();
    return (dq.size() > 0) && (tq.size() > 0);
  endfunction

  function automatic bit m_ready();
    return (tq.size() < 8) && (m_credits >= int'(rd_issue_len) + 1);
  endfunction

  task automatic model_reset();
    tq.delete();
    dq.delete();
    m_credits   = 32;
    m_idx       = 0;
    m_orphan    = 0;
    m_ovf       = 0;
    pending_dfi = 0;
  endtask

  task automatic check_outputs();
    chk("rvalid", rvalid, m_rvalid());
    chk("rd_issue_ready", rd_issue_ready, m_ready());
    chk("err_orphan", err_orphan, m_orphan);
    chk("err_overflow", err_overflow, m_ovf);
    if (m_rvalid()) begin
      chk("rid", rid, tq[0].id);
      chk("rdata", rdata, dq[0].d);
      chk("rlast", rlast, m_idx == tq[0].len);
      chk("rresp", rresp, (PAR_EN && dq[0].perr) ? 2'b10 : 2'b00);
    end else begin
      chk("rid_idle", rid, 0);
      chk("rdata_idle", rdata, 0);
      chk("rlast_idle", rlast, 0);
      chk("rresp_idle", rresp, 0);
    end
  endtask

  // Apply one clock edge's worth of spec behaviour to the model.
  task automatic model_edge();
    bit hs, issue;
    int nl;
    if (rst) begin
      model_reset();
      return;
    end
    hs    = m_rvalid() && rready;
    issue = rd_issue_valid && m_ready();
    nl    = int'(rd_issue_len) + 1;
    if (dfi_rddata_valid) begin
      if (tq.size() == 0) m_orphan = 1;
      else if (dq.size() == 32 && !hs) m_ovf = 1;
      else dq.push_back('{d: dfi_rddata, perr: (even_par(dfi_rddata) != dfi_rddata_par)});
    end
    if (hs) begin
      void'(dq.pop_front());
      if (m_idx == tq[0].len) begin
        void'(tq.pop_front());
        m_idx = 0;
      end else m_idx++;
    end
    if (issue) begin
      tq.push_back('{id: int'(rd_issue_id), len: int'(rd_issue_len)});
      pending_dfi += nl;
    end
    m_credits = m_credits - (issue ? nl : 0) + (hs ? 1 : 0);
    if (m_credits > 32) m_credits = 32;
  endtask

  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    rd_issue_valid   = 0;
    rd_issue_id      = 0;
    rd_issue_len     = 0;
    dfi_rddata_valid = 0;
    dfi_rddata       = 0;
    dfi_rddata_par   = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rready = 0;
    rst    = 1;
    cycle();
    rst = 0;
  endtask

  task automatic set_beat(input logic [63:0] d, input bit corrupt0);
    dfi_rddata_valid = 1;
    dfi_rddata       = d;
    dfi_rddata_par   = even_par(d) ^ {7'b0, corrupt0};
    if (pending_dfi > 0) pending_dfi--;
  endtask

  initial begin
    model_reset();
    idle_inputs();
    rready = 0;
    rst = 1;
    @(posedge clk);
    #1;
    do_reset();

    // Reset state
    #1;
    chk("reset_rvalid", rvalid, 0);
    chk("reset_ready", rd_issue_ready, 1);
    chk("reset_errs", {err_orphan, err_overflow}, 0);

    // 1: single burst id=3 len=3, data A0..A3, rready high
    rready = 1;
    rd_issue_valid = 1; rd_issue_id = 3; rd_issue_len = 3;
    cycle();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      set_beat(64'hA0 + 64'(i), 0);
      cycle();
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) cycle();

    // 2: credits exhausted by two len=15 bursts; overflow on a 33rd beat
    do_reset();
    for (int i = 0; i < 2; i++) begin
      rd_issue_valid = 1; rd_issue_id = 4'(i + 7); rd_issue_len = 15;
      cycle();
    end
    rd_issue_valid = 0; rd_issue_len = 0;
    #1;
    chk("t2_blocked", rd_issue_ready, 0);
    for (int i = 0; i < 33; i++) begin
      set_beat({32'hC0DE0000, 32'(i)}, 0);
      cycle();
    end
    idle_inputs();
    cycle();
    rready = 1;
    cycle();
    rready = 0;
    #1;
    chk("t2_ready_after_hs", rd_issue_ready, 1);
    chk("t2_overflow", err_overflow, 1);
    rready = 1;
    for (int i = 0; i < 33; i++) cycle();

    // 3: two bursts with rready toggling; outputs held while stalled
    do_reset();
    rd_issue_valid = 1; rd_issue_id = 1; rd_issue_len = 1;
    cycle();
    rd_issue_id = 2; rd_issue_len = 0;
    set_beat(64'h1111_0000, 0);
    cycle();
    rd_issue_valid = 0;
    set_beat(64'h1111_0001, 0);
    cycle();
    set_beat(64'h2222_0000, 0);
    cycle();
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      rready = (i % 2 == 0);
      cycle();
    end

    // 4: orphan beat with nothing outstanding
    do_reset();
    set_beat(64'hDEAD_BEEF, 0);
    cycle();
    idle_inputs();
    for (int i = 0; i < 3; i++) cycle();
    #1;
    chk("t4_orphan_sticky", err_orphan, 1);
    chk("t4_no_rvalid", rvalid, 0);

    // 5: reset in the middle of a 4-beat burst
    do_reset();
    rready = 1;
    rd_issue_valid = 1; rd_issue_id = 5; rd_issue_len = 3;
    cycle();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      set_beat(64'h5500 + 64'(i), 0);
      cycle();
    end
    idle_inputs();
    rst = 1;
    cycle();
    rst = 0;
    #1;
    chk("t5_rvalid_flushed", rvalid, 0);
    chk("t5_orphan_cleared", err_orphan, 0);
    for (int i = 0; i < 2; i++) begin
      rd_issue_valid = 1; rd_issue_id = 9; rd_issue_len = 15;
      cycle();
    end
    idle_inputs();
    cycle();

    // 6: parity corruption on beat 1 of a len=1 burst
    do_reset();
    rready = 1;
    rd_issue_valid = 1; rd_issue_id = 6; rd_issue_len = 1;
    cycle();
    idle_inputs();
    set_beat(64'h0123_4567_89AB_CDEF, 0);
    cycle();
    set_beat(64'hFEDC_BA98_7654_3210, 1);
    cycle();
    idle_inputs();
    for (int i = 0; i < 3; i++) cycle();

    // Randomized traffic with credit-respecting DFI returns
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      idle_inputs();
      rready = ($urandom_range(3) != 0);
      rd_issue_valid = ($urandom_range(2) == 0);
      rd_issue_id    = 4'($urandom);
      rd_issue_len   = ($urandom_range(3) == 0) ? 4'($urandom) : 4'($urandom_range(3));
      if (pending_dfi > 0 && $urandom_range(3) != 0)
        set_beat({$urandom, $urandom}, ($urandom_range(7) == 0));
      cycle();
    end
    idle_inputs();
    rready = 1;
    begin
      int budget = 2000;
      while ((pending_dfi > 0 || tq.size() > 0) && budget > 0) begin
        idle_inputs();
        if (pending_dfi > 0) set_beat({$urandom, $urandom}, 0);
        cycle();
        budget--;
      end
      chk("drain_budget", budget > 0, 1);
    end
    idle_inputs();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
